ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Shared work-RAM arbiter between a 68000 CPU port and a DMA port.
// Define RAM_ARB_FAIR_EN for round-robin arbitration; default is CPU priority.
module ram_arbiter #(
  parameter int ADDR_WIDTH  = 11,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_as_n,
  input  logic                  cpu_rw,
  input  logic                  cpu_uds_n,
  input  logic                  cpu_lds_n,
  input  logic                  cpu_ram_cs,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]           cpu_dout,
  output logic [15:0]           cpu_din,
  output logic                  cpu_dtack_n,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [15:0]           dma_din,
  output logic                  dma_ack,
  output logic [15:0]           dma_dout,
  output logic                  ram_we,
  output logic [1:0]            ram_mask,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_din,
  input  logic [15:0]           ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    CPU_HOLD,
    DMA_ACC
  } state_t;

  localparam logic [4:0] CPU_LAST = 5'(WAIT_STATES + 1);
  localparam logic [4:0] DMA_LAST = 5'd1;

  state_t                state_q;
  state_t                state_d;
  logic [4:0]            cnt_q;
  logic [4:0]            cnt_d;
  logic                  served_q;
  logic                  served_d;
  logic                  abort_q;
  logic                  abort_d;
  logic                  ram_we_d;
  logic [1:0]            ram_mask_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [15:0]           ram_din_d;
  logic [15:0]           cpu_din_d;
  logic                  dtack_d;
  logic                  ack_d;
  logic [15:0]           dma_dout_d;
  logic                  cpu_req;
  logic                  grant_cpu;
  logic                  grant_dma;

  assign cpu_req = cpu_ram_cs & ~cpu_as_n & ~served_q;

`ifdef RAM_ARB_FAIR_EN
  // last_dma_q is last_grant: 0 = CPU, 1 = DMA
  logic last_dma_q;
  logic last_dma_d;
  assign grant_cpu = cpu_req & (~dma_req | last_dma_q);
`else
  assign grant_cpu = cpu_req;
`endif
  assign grant_dma = dma_req & ~grant_cpu;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    served_d   = served_q & ~cpu_as_n;
    abort_d    = abort_q | cpu_as_n;
    ram_we_d   = 1'b0;
    ram_mask_d = ram_mask;
    ram_addr_d = ram_addr;
    ram_din_d  = ram_din;
    cpu_din_d  = cpu_din;
    dtack_d    = cpu_dtack_n;
    ack_d      = 1'b0;
    dma_dout_d = dma_dout;
`ifdef RAM_ARB_FAIR_EN
    last_dma_d = last_dma_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_cpu) begin
          ram_addr_d = cpu_addr;
          ram_din_d  = cpu_dout;
          ram_mask_d = {~cpu_uds_n, ~cpu_lds_n};
          ram_we_d   = ~cpu_rw;
          served_d   = 1'b1;
          abort_d    = 1'b0;
          state_d    = CPU_ACC;
`ifdef RAM_ARB_FAIR_EN
          last_dma_d = 1'b0;
`endif
        end else if (grant_dma) begin
          ram_addr_d = dma_addr;
          ram_din_d  = dma_din;
          ram_mask_d = 2'b11;
          ram_we_d   = dma_we;
          state_d    = DMA_ACC;
`ifdef RAM_ARB_FAIR_EN
          last_dma_d = 1'b1;
`endif
        end
      end
      CPU_ACC: begin
        if (cnt_q == CPU_LAST) begin
          // a strobe that went away mid-cycle gets no DTACK
          if (abort_q | cpu_as_n) begin
            state_d = IDLE;
          end else begin
            cpu_din_d = ram_dout;
            dtack_d   = 1'b0;
            state_d   = CPU_HOLD;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      CPU_HOLD: begin
        if (cpu_as_n) begin
          dtack_d = 1'b1;
          state_d = IDLE;
        end
      end
      DMA_ACC: begin
        if (cnt_q == DMA_LAST) begin
          dma_dout_d = ram_dout;
          ack_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      served_q    <= 1'b0;
      abort_q     <= 1'b0;
      ram_we      <= 1'b0;
      ram_mask    <= '0;
      ram_addr    <= '0;
      ram_din     <= '0;
      cpu_din     <= '0;
      cpu_dtack_n <= 1'b1;
      dma_ack     <= 1'b0;
      dma_dout    <= '0;
`ifdef RAM_ARB_FAIR_EN
      last_dma_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      served_q    <= served_d;
      abort_q     <= abort_d;
      ram_we      <= ram_we_d;
      ram_mask    <= ram_mask_d;
      ram_addr    <= ram_addr_d;
      ram_din     <= ram_din_d;
      cpu_din     <= cpu_din_d;
      cpu_dtack_n <= dtack_d;
      dma_ack     <= ack_d;
      dma_dout    <= dma_dout_d;
`ifdef RAM_ARB_FAIR_EN
      last_dma_q  <= last_dma_d;
`endif
    end
  end

endmodule
